// File: rtl/two24_pkg.sv
// Shared types for the TWO24 packed-result unpacker.
// Optional build macro: TWO24_UNPACK_SAT_EN (saturate a lane on carry).
package two24_pkg;

   localparam int LANE_W = 24;
   localparam int NLANES = 2;

   typedef logic [NLANES*LANE_W-1:0] two24_word_t;

   typedef struct packed {
      logic [NLANES-1:0] c;
      two24_word_t       p;
   } two24_ent_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LANE0 = 2'd1,
      ST_LANE1 = 2'd2
   } two24_state_e;

endpackage

// File: rtl/two24_unpack_if.sv
// Packed-word input stream and unpacked-lane output stream of two24_unpack.
// Optional build macro: TWO24_UNPACK_SAT_EN (no effect on this file).
interface two24_unpack_if;

   logic [47:0] p;
   logic [1:0]  carry;
   logic        in_valid;
   logic        in_ready;
   logic [24:0] dat;
   logic        lane;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output p, carry, in_valid, out_ready,
      input  in_ready, dat, lane, out_valid
   );

   modport slave (
      input  p, carry, in_valid, out_ready,
      output in_ready, dat, lane, out_valid
   );

endinterface

// File: rtl/two24_fifo.sv
// Synchronous FIFO of {carry, packed word}; exposes the head and next entry.
// Optional build macro: TWO24_UNPACK_SAT_EN (no effect on this file).
module two24_fifo
   import two24_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  two24_ent_t    wdata_i,
   input  logic          pop_i,
   output two24_ent_t    head0_o,
   output two24_ent_t    head1_o,
   output logic [CW-1:0] cnt_o,
   output logic          avail_o
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   two24_ent_t    mem_q [DEPTH];
   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          avail_q;

   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (push_i) wp_d = wp_q + AW'(1);
      if (pop_i)  rp_d = rp_q + AW'(1);
      if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
      else if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         avail_q <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         avail_q <= (cnt_d != FULL);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wp_q] <= wdata_i;
   end

   assign head0_o = mem_q[rp_q];
   assign head1_o = mem_q[rp_q + AW'(1)];
   assign cnt_o   = cnt_q;
   assign avail_o = avail_q;

endmodule

// File: rtl/two24_unpack.sv
// Splits packed TWO24 DSP results into two 25-bit lane beats (carry in bit 24).
// Optional build macro: TWO24_UNPACK_SAT_EN (lane forced to all-ones on carry).
module two24_unpack
   import two24_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [47:0] P_i,
   input  logic [1:0]  CARRY_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic [24:0] dat_o,
   output logic        lane_o,
   output logic        valid_o,
   input  logic        ready_i
);

   localparam int CW = $clog2(DEPTH) + 1;

   two24_state_e   state_q, state_d;
   logic [24:0]    dat_q, dat_d;
   logic           lane_q, lane_d;
   two24_ent_t     in_w, head0, head1, nxt;
   logic [CW-1:0]  cnt;
   logic           push, pop, two_q, more;

   function automatic logic [24:0] fmt(input logic c,
                                       input logic [LANE_W-1:0] d);
`ifdef TWO24_UNPACK_SAT_EN
      return {c, c ? {LANE_W{1'b1}} : d};
`else
      return {c, d};
`endif
   endfunction

   assign in_w  = '{c: CARRY_i, p: P_i};
   assign push  = valid_i & ready_o;
   assign pop   = (state_q == ST_LANE1) & ready_i;
   assign two_q = (cnt > CW'(1));
   assign more  = two_q | push;
   // An empty queue behind the head means the next word is the one arriving now.
   assign nxt   = two_q ? head1 : in_w;

   two24_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .wdata_i (in_w),
      .pop_i   (pop),
      .head0_o (head0),
      .head1_o (head1),
      .cnt_o   (cnt),
      .avail_o (ready_o)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         dat_q   <= '0;
         lane_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dat_q   <= dat_d;
         lane_q  <= lane_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (push)    state_d = ST_LANE0;
         ST_LANE0: if (ready_i) state_d = ST_LANE1;
         ST_LANE1: if (ready_i) state_d = more ? ST_LANE0 : ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      dat_d  = dat_q;
      lane_d = lane_q;
      unique case (state_q)
         ST_IDLE: if (push) begin
            dat_d  = fmt(in_w.c[0], in_w.p[LANE_W-1:0]);
            lane_d = 1'b0;
         end
         ST_LANE0: if (ready_i) begin
            dat_d  = fmt(head0.c[1], head0.p[2*LANE_W-1:LANE_W]);
            lane_d = 1'b1;
         end
         ST_LANE1: if (ready_i && more) begin
            dat_d  = fmt(nxt.c[0], nxt.p[LANE_W-1:0]);
            lane_d = 1'b0;
         end
         default: ;
      endcase
   end

   assign valid_o = (state_q != ST_IDLE);
   assign dat_o   = dat_q;
   assign lane_o  = lane_q;

endmodule

// File: tb/tb_two24_unpack.sv
// Directed self-checking bench for two24_unpack with a lane-order model.
// Honours TWO24_UNPACK_SAT_EN for expected saturated lanes.
module tb_two24_unpack;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   two24_unpack_if bus();

   always #5 clk = ~clk;

   two24_unpack #(.DEPTH(DEPTH)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .P_i     (bus.p),
      .CARRY_i (bus.carry),
      .valid_i (bus.in_valid),
      .ready_o (bus.in_ready),
      .dat_o   (bus.dat),
      .lane_o  (bus.lane),
      .valid_o (bus.out_valid),
      .ready_i (bus.out_ready)
   );

   int          nchk = 0;
   int          nfail = 0;
   int          nacc = 0;
   int          nbeat = 0;
   logic [25:0] expq [$];
   logic        pv = 1'b0;
   logic        pr = 1'b0;
   logic        pl = 1'b0;
   logic [24:0] pd = '0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      if (obs !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [24:0] fmt(input logic c, input logic [23:0] d);
`ifdef TWO24_UNPACK_SAT_EN
      return {c, c ? 24'hFFFFFF : d};
`else
      return {c, d};
`endif
   endfunction

   function automatic logic [47:0] wrd(input int i);
      return {24'(i * 7 + 3), 24'(i * 5 + 1)};
   endfunction

   // Called at a negedge: drive, check the beat about to complete, advance.
   task automatic cyc(input logic v, input logic [47:0] p,
                      input logic [1:0] c, input logic r);
      logic [25:0] e;
      bus.in_valid  = v;
      bus.p         = p;
      bus.carry     = c;
      bus.out_ready = r;
      if (pv && !pr) begin
         chk("hold_v", 32'(bus.out_valid), 32'd1);
         chk("hold_d", 32'({bus.lane, bus.dat}), 32'({pl, pd}));
      end
      if (bus.out_valid && r) begin
         nbeat++;
         if (expq.size() == 0) chk("extra_beat", 32'(expq.size()), 32'd1);
         else begin
            e = expq.pop_front();
            chk("beat", 32'({bus.lane, bus.dat}), 32'(e));
         end
      end
      if (v && bus.in_ready) begin
         nacc++;
         expq.push_back({1'b0, fmt(c[0], p[23:0])});
         expq.push_back({1'b1, fmt(c[1], p[47:24])});
      end
      pv = bus.out_valid;
      pr = r;
      pd = bus.dat;
      pl = bus.lane;
      @(negedge clk);
   endtask

   task automatic drain(input int lim);
      for (int i = 0; i < lim && expq.size() != 0; i++) cyc(1'b0, '0, '0, 1'b1);
      chk("drained", 32'(expq.size()), 32'd0);
      repeat (2) cyc(1'b0, '0, '0, 1'b1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.p         = '0;
      bus.carry     = '0;
      bus.out_ready = 1'b0;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_dat", 32'(bus.dat), 32'd0);
      chk("rst_lane", 32'(bus.lane), 32'd0);
      chk("rst_rdy", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rdy_after_rst", 32'(bus.in_ready), 32'd1);

      cyc(1'b1, 48'h000002_000001, 2'b00, 1'b1);
      chk("t1_l0", 32'({bus.out_valid, bus.lane, bus.dat}), 32'h0400_0001);
      cyc(1'b0, '0, '0, 1'b1);
      chk("t1_l1", 32'({bus.out_valid, bus.lane, bus.dat}), 32'h0600_0002);
      cyc(1'b0, '0, '0, 1'b1);
      chk("t1_idle", 32'(bus.out_valid), 32'd0);
      chk("t1_keep", 32'(bus.dat), 32'h000_0002);

      cyc(1'b1, 48'h000010_FFFFFF, 2'b01, 1'b1);
      chk("t2_l0", 32'({bus.lane, bus.dat}), 32'h01FF_FFFF);
      cyc(1'b0, '0, '0, 1'b1);
      chk("t2_l1", 32'({bus.lane, bus.dat}), 32'h0200_0010);
      cyc(1'b0, '0, '0, 1'b1);

      cyc(1'b1, 48'h123456_000000, 2'b10, 1'b1);
      chk("t3_l0", 32'({bus.lane, bus.dat}), 32'h0000_0000);
      cyc(1'b0, '0, '0, 1'b1);
`ifdef TWO24_UNPACK_SAT_EN
      chk("t3_l1", 32'({bus.lane, bus.dat}), 32'h03FF_FFFF);
`else
      chk("t3_l1", 32'({bus.lane, bus.dat}), 32'h0312_3456);
`endif
      cyc(1'b0, '0, '0, 1'b1);

      for (int i = 0; i < 6; i++) begin
         cyc(i < 3, wrd(i), 2'(i), 1'b1);
         chk("tput_v", 32'(bus.out_valid), 32'd1);
      end
      drain(8);

      nacc = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) chk("full_rdy", 32'(bus.in_ready), 32'd0);
         cyc(1'b1, wrd(10 + i), 2'(i), 1'b0);
      end
      chk("acc4", 32'(nacc), 32'd4);
      nbeat = 0;
      drain(20);
      chk("beats8", 32'(nbeat), 32'd8);

      for (int i = 0; i < 16; i++)
         cyc((i % 3 == 0) && (i < 12), wrd(20 + i), 2'(i + 1), 1'((i % 2) == 1));
      drain(30);

      cyc(1'b1, wrd(40), 2'b11, 1'b0);
      cyc(1'b1, wrd(41), 2'b00, 1'b0);
      cyc(1'b1, wrd(42), 2'b00, 1'b0);
      cyc(1'b0, '0, '0, 1'b1);
      chk("t6_in_l1", 32'({bus.out_valid, bus.lane}), 32'd3);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_v", 32'(bus.out_valid), 32'd0);
      chk("t6_rst_d", 32'(bus.dat), 32'd0);
      chk("t6_rst_r", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      expq.delete();
      pv = 1'b0;
      @(negedge clk);
      chk("t6_rdy", 32'(bus.in_ready), 32'd1);
      chk("t6_idle", 32'(bus.out_valid), 32'd0);
      nbeat = 0;
      repeat (4) cyc(1'b0, '0, '0, 1'b1);
      chk("t6_stale", 32'(nbeat), 32'd0);
      cyc(1'b1, 48'h0000AB_0000CD, 2'b00, 1'b1);
      chk("t6_new", 32'({bus.lane, bus.dat}), 32'h0000_00CD);
      drain(8);
      chk("t6_beats", 32'(nbeat), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/two24_unpack.md
TWO24_UNPACK -- requirements
Module: two24_unpack

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning packed-word FIFO entries; power of two, at least 2.
REQ-002 SHALL have port clk_i, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port P_i, input, 48 bits, meaning the packed TWO24 DSP result: lane0 is [23:0], lane1 is [47:24].
REQ-005 SHALL have port CARRY_i, input, 2 bits, meaning per-lane carry-out: bit0 is lane0, bit1 is lane1.
REQ-006 SHALL have port valid_i, input, 1 bit, meaning P_i/CARRY_i are valid this cycle.
REQ-007 SHALL have port ready_o, output, 1 bit, meaning the block accepts a packed word this cycle.
REQ-008 SHALL have port dat_o, output, 25 bits, meaning one unpacked lane with its carry in bit 24.
REQ-009 SHALL have port lane_o, output, 1 bit, meaning the lane index of dat_o (0 or 1).
REQ-010 SHALL have port valid_o, output, 1 bit, meaning dat_o/lane_o are valid.
REQ-011 SHALL have port ready_i, input, 1 bit, meaning the downstream accepts dat_o this cycle.

Function
REQ-012 SHALL push {CARRY_i, P_i} into the FIFO on any cycle with valid_i=1 and ready_o=1; with valid_i=1 and ready_o=0 the word is dropped and state is unchanged.
REQ-013 SHALL drive ready_o = (occupancy != DEPTH), decoded from registered occupancy; no full-FIFO pass-through: a pop and a push in the same cycle while full are not both taken.
REQ-014 SHALL run output FSM IDLE -> LANE0 -> LANE1 -> (LANE0 if FIFO non-empty, else IDLE).
REQ-015 SHALL, in LANE0, register dat_o = {C[0], P[23:0]} and lane_o = 0; in LANE1, register dat_o = {C[1], P[47:24]} and lane_o = 1.
REQ-016 SHALL advance LANE0 -> LANE1 only on valid_o & ready_i; LANE1 exits only on valid_o & ready_i, popping the head word in that same cycle.
REQ-017 SHALL hold valid_o, dat_o and lane_o stable while valid_o=1 and ready_i=0.
REQ-018 SHALL give a latency of 1 cycle: a word pushed at cycle N into an empty FIFO with the FSM in IDLE presents lane0 with valid_o=1 at N+1.
REQ-019 SHALL sustain one packed word per 2 cycles when ready_i is held at 1, with no idle cycle between consecutive words.
REQ-020 SHALL keep occupancy in the range 0..DEPTH; pointers wrap modulo DEPTH; a simultaneous push and pop leaves occupancy unchanged.
REQ-021 SHALL drive valid_o=0 in IDLE; dat_o retains its last value there.

Reset
REQ-022 SHALL, while rst_i=1 at a clock edge: occupancy=0, pointers=0, FSM=IDLE, valid_o=0, dat_o=0, lane_o=0, ready_o=0.
REQ-023 SHALL drive ready_o=1 on the first cycle after rst_i deasserts.
REQ-024 SHALL discard an in-flight word, including a half-emitted word in LANE1, when reset is asserted mid-operation; lane1 of that word is never emitted.

Configuration
REQ-025 SHALL, with TWO24_UNPACK_SAT_EN defined, drive dat_o[23:0] = 24'hFFFFFF whenever the lane carry is 1; dat_o[24] still carries the carry.
REQ-026 SHALL, without TWO24_UNPACK_SAT_EN, emit the raw 24-bit lane sum with the carry in bit 24.

Structure
REQ-027 SHALL place LANE_W=24, NLANES=2, typedef two24_word_t (48-bit), and the FSM state enum in shared package two24_pkg.
REQ-028 SHALL implement storage as sub-module two24_fifo, a synchronous FIFO of width 50 and depth DEPTH; the FSM and unpack logic live in the top module.

Verification
REQ-029 SHALL cover: push P=0x000002_000001, C=0, ready_i=1 -> dat_o=0x0000001 (lane0) at N+1, then 0x0000002 (lane1) at N+2.
REQ-030 SHALL cover: P=0x000010_FFFFFF, C=2'b01 -> lane0 = 0x1FFFFFF in both builds; lane1 = 0x0000010.
REQ-031 SHALL cover: P=0x123456_000000, C=2'b10 -> lane1 = 0x1123456 without the macro, 0x1FFFFFF with it.
REQ-032 SHALL cover: ready_i=0, push 5 words with DEPTH=4 -> 4 accepted, ready_o=0, 5th dropped; then ready_i=1 -> exactly 8 beats in order.
REQ-033 SHALL cover: ready_i toggling 1/0 -> dat_o held while stalled, no duplicated or lost lanes versus the reference model.
REQ-034 SHALL cover: rst_i pulsed while in LANE1 with 2 words queued -> valid_o=0 next cycle, ready_o=1 the cycle after, FIFO empty, no stale output.
